// File: rtl/dcache_mem_pkg.sv
// Shared constants and FSM state encoding for the line-granular data memory
// behind the data cache's miss/write-back controller.
package dcache_mem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'h0,
    STATE_BUSY = 2'h1,
    STATE_DONE = 2'h2
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: synchronous write port, and a read port whose data is
// registered and held until the next read.
module dcache_line_array
  import dcache_mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [LINE_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [LINE_BITS-1:0] o_rd_data
);

  logic [LINE_BITS-1:0] r_mem [DEPTH];
  logic [LINE_BITS-1:0] r_rd_data;

  // Storage contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dcache_line_memory.sv
// Fixed-latency 256-bit line memory: captures a request on acceptance,
// completes it LATENCY cycles later with a one-cycle ack.
//
//   state      | meaning
//   STATE_IDLE | waiting for enable_i; request captured on the accepting edge
//   STATE_BUSY | latency counter running, inputs ignored
//   STATE_DONE | ack cycle; read data already on data_o, write commits at end
module dcache_line_memory
  import dcache_mem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o,
  output logic                 busy_o
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [7:0] C_TC  = 8'(LATENCY - 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_count;
  logic [7:0]            w_count_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [LINE_BITS-1:0]  r_wdata;
  logic                  r_ack;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused_addr;

  // Upper address bits are dropped, so line indices wrap modulo DEPTH.
  assign w_idx         = addr_i[OFFSET_BITS +: IDX_W];
  assign w_unused_addr = ^addr_i;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        if (enable_i) begin
          w_accept    = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = STATE_BUSY;
        end
      end
      STATE_BUSY: begin
        if (r_count == C_TC) begin
          w_state_nxt = STATE_DONE;
          w_rd_en     = ~r_write;
        end else begin
          w_count_nxt = r_count + 8'd1;
        end
      end
      STATE_DONE: begin
        w_wr_en     = r_write;
        w_state_nxt = STATE_IDLE;
      end
      default: begin
        w_state_nxt = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= STATE_IDLE;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ack   <= (w_state_nxt == STATE_DONE);
      r_busy  <= (w_state_nxt != STATE_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_idx   <= w_idx;
      r_write <= write_i;
      r_wdata <= data_i;
    end
  end

  dcache_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (r_idx),
    .o_rd_data (data_o)
  );

  assign ack_o  = r_ack;
  assign busy_o = r_busy;

endmodule
